// File: rtl/fifo_word_packer_if.sv
// FIFO connection bundle shared by a FIFO and its reader; fillStatus carries
// the head-valid flag plus occupancy information.
interface fifoConnect #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32
);
    localparam int LEVELBITS = $clog2(DEPTH + 1);

    typedef struct packed {
        logic                 valid;
        logic                 full;
        logic [LEVELBITS-1:0] level;
    } fill_status_t;

    logic             read;
    logic             write;
    logic [WIDTH-1:0] datain;
    logic [WIDTH-1:0] dataout;
    fill_status_t     fillStatus;

    modport reader (
        output read,
        output write,
        output datain,
        input  dataout,
        input  fillStatus
    );

    modport fifo (
        input  read,
        input  write,
        input  datain,
        output dataout,
        output fillStatus
    );
endinterface

// File: rtl/fifo_word_packer.sv
// Pops WIDTH-bit words from a FIFO and packs RATIO of them into one wide beat
// presented on a valid/ready stream; flush pushes out a partially filled beat.
module fifo_word_packer #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 32,
    parameter int RATIO     = 4,
    parameter int COUNTBITS = $clog2(RATIO + 1)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    fifoConnect.reader             link,
    input  logic                   flush,
    output logic [WIDTH*RATIO-1:0] out_data,
    output logic [COUNTBITS-1:0]   out_count,
    output logic                   out_last,
    output logic                   out_valid,
    input  logic                   out_ready
);

    if (RATIO < 1) begin : g_bad_ratio
        $error("fifo_word_packer: RATIO must be at least 1");
    end
    if (DEPTH < 1) begin : g_bad_depth
        $error("fifo_word_packer: DEPTH must be at least 1");
    end

    typedef enum logic [0:0] {StFill, StHold} state_e;

    state_e                 state_q, state_d;
    logic [COUNTBITS-1:0]   cnt_q, cnt_d;
    logic [WIDTH*RATIO-1:0] acc_q, acc_d;
    logic                   last_q, last_d;
    logic                   pop;

    // State and beat registers; reset discards any partial beat at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StFill;
            cnt_q   <= '0;
            acc_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            last_q  <= last_d;
        end
    end

    // Next state: lane fill, full/flush close of a beat, transfer and refill.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        last_d  = last_q;
        unique case (state_q)
            StFill: begin
                if (pop) begin
                    for (int i = 0; i < RATIO; i++) begin
                        if (i == int'(cnt_q)) begin
                            acc_d[i*WIDTH +: WIDTH] = link.dataout;
                        end
                    end
                    cnt_d = cnt_q + 1'b1;
                end
                if (pop && (int'(cnt_q) + 1 == RATIO)) begin
                    state_d = StHold;
                    last_d  = 1'b0;
                end else if (flush && (pop || cnt_q != '0)) begin
                    state_d = StHold;
                    last_d  = 1'b1;
                end
            end
            StHold: begin
                if (out_ready) begin
                    // Beat leaves; lanes above the new count must read as zero.
                    acc_d   = '0;
                    cnt_d   = '0;
                    last_d  = 1'b0;
                    state_d = StFill;
                    if (pop) begin
                        acc_d[WIDTH-1:0] = link.dataout;
                        cnt_d            = COUNTBITS'(1);
                        if (RATIO == 1) begin
                            state_d = StHold;
                        end else if (flush) begin
                            state_d = StHold;
                            last_d  = 1'b1;
                        end
                    end
                end else if (flush) begin
                    last_d = 1'b1;
                end
            end
            default: state_d = StFill;
        endcase
    end

    // FIFO handshake: pop only when a head word exists and the beat can take it.
    always_comb begin
        link.read   = reset_n && link.fillStatus.valid && ((state_q == StFill) || out_ready);
        link.write  = 1'b0;
        link.datain = '0;
    end

    assign pop       = link.read;
    assign out_data  = acc_q;
    assign out_count = cnt_q;
    assign out_last  = last_q;
    assign out_valid = (state_q == StHold);

endmodule

// File: tb/tb_fifo_word_packer.sv
// Directed bench for fifo_word_packer: behavioural FIFOs feed a RATIO=4 and a
// RATIO=1 instance; beats are checked against a scoreboard of expected beats.
module tb_fifo_word_packer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n     = 1'b0;
    logic flush     = 1'b0;
    logic out_ready = 1'b0;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- RATIO = 4 instance and its FIFO model ----------------
    fifoConnect #(.WIDTH(32), .DEPTH(16)) f4 ();

    logic [127:0] out_data4;
    logic [2:0]   out_count4;
    logic         out_last4;
    logic         out_valid4;

    fifo_word_packer #(.WIDTH(32), .DEPTH(16), .RATIO(4)) u_dut4 (
        .clk       (clk),
        .reset_n   (rst_n),
        .link      (f4),
        .flush     (flush),
        .out_data  (out_data4),
        .out_count (out_count4),
        .out_last  (out_last4),
        .out_valid (out_valid4),
        .out_ready (out_ready)
    );

    logic [31:0] mem4 [64];
    logic [5:0]  wp4 = '0;
    logic [5:0]  rp4 = '0;
    logic [5:0]  lvl4;
    logic        push4 = 1'b0;
    logic [31:0] push_data4 = '0;

    always @(posedge clk) begin
        if (push4) begin
            mem4[wp4] <= push_data4;
            wp4       <= wp4 + 1'b1;
        end
        if (f4.read) rp4 <= rp4 + 1'b1;
    end
    assign lvl4          = wp4 - rp4;
    assign f4.dataout    = mem4[rp4];
    assign f4.fillStatus = {(lvl4 != 6'd0), (lvl4 >= 6'd16), lvl4[4:0]};

    // ---------------- RATIO = 1 instance and its FIFO model ----------------
    fifoConnect #(.WIDTH(32), .DEPTH(16)) f1 ();

    logic [31:0] out_data1;
    logic [0:0]  out_count1;
    logic        out_last1;
    logic        out_valid1;

    fifo_word_packer #(.WIDTH(32), .DEPTH(16), .RATIO(1)) u_dut1 (
        .clk       (clk),
        .reset_n   (rst_n),
        .link      (f1),
        .flush     (flush),
        .out_data  (out_data1),
        .out_count (out_count1),
        .out_last  (out_last1),
        .out_valid (out_valid1),
        .out_ready (out_ready)
    );

    logic [31:0] mem1 [64];
    logic [5:0]  wp1 = '0;
    logic [5:0]  rp1 = '0;
    logic [5:0]  lvl1;
    logic        push1 = 1'b0;
    logic [31:0] push_data1 = '0;

    always @(posedge clk) begin
        if (push1) begin
            mem1[wp1] <= push_data1;
            wp1       <= wp1 + 1'b1;
        end
        if (f1.read) rp1 <= rp1 + 1'b1;
    end
    assign lvl1          = wp1 - rp1;
    assign f1.dataout    = mem1[rp1];
    assign f1.fillStatus = {(lvl1 != 6'd0), (lvl1 >= 6'd16), lvl1[4:0]};

    // ---------------- scoreboards ----------------
    typedef struct {
        logic [127:0] data;
        logic [2:0]   count;
        logic         last;
    } beat4_t;

    typedef struct {
        logic [31:0] data;
        logic [0:0]  count;
        logic        last;
    } beat1_t;

    beat4_t sb4[$];
    beat1_t sb1[$];
    int     xfer_cyc4[$];
    int     rd_cyc4[$];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp)
        else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic exp4(input logic [127:0] d, input logic [2:0] c, input logic l);
        beat4_t b;
        b.data  = d;
        b.count = c;
        b.last  = l;
        sb4.push_back(b);
    endtask

    task automatic exp1(input logic [31:0] d);
        beat1_t b;
        b.data  = d;
        b.count = 1'b1;
        b.last  = 1'b0;
        sb1.push_back(b);
    endtask

    // Read pulses of the RATIO=4 FIFO, by cycle.
    always @(posedge clk) begin
        if (f4.read) rd_cyc4.push_back(cyc);
    end

    // Beat monitor, RATIO=4: a beat transfers at the next rising edge.
    always @(negedge clk) begin
        if (rst_n && out_valid4 && out_ready) begin
            beat4_t e;
            checks++;
            assert (sb4.size() != 0)
            else begin
                failures++;
                $error("FAIL beat4_expected got=%h exp=none", out_data4);
            end
            if (sb4.size() != 0) begin
                e = sb4.pop_front();
                chk("beat4_data", out_data4, e.data);
                chk("beat4_count", 128'(out_count4), 128'(e.count));
                chk("beat4_last", 128'(out_last4), 128'(e.last));
                xfer_cyc4.push_back(cyc);
            end
        end
    end

    // Beat monitor, RATIO=1.
    always @(negedge clk) begin
        if (rst_n && out_valid1 && out_ready) begin
            beat1_t e;
            checks++;
            assert (sb1.size() != 0)
            else begin
                failures++;
                $error("FAIL beat1_expected got=%h exp=none", out_data1);
            end
            if (sb1.size() != 0) begin
                e = sb1.pop_front();
                chk("beat1_data", 128'(out_data1), 128'(e.data));
                chk("beat1_count", 128'(out_count1), 128'(e.count));
                chk("beat1_last", 128'(out_last1), 128'(e.last));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word4(input logic [31:0] w);
        push4      = 1'b1;
        push_data4 = w;
        step();
        push4      = 1'b0;
    endtask

    task automatic push_word1(input logic [31:0] w);
        push1      = 1'b1;
        push_data1 = w;
        step();
        push1      = 1'b0;
    endtask

    task automatic drain4(input string tag);
        for (int i = 0; i < 40 && sb4.size() != 0; i++) step();
        chk(tag, 128'(sb4.size()), 128'(0));
    endtask

    task automatic drain1(input string tag);
        for (int i = 0; i < 40 && sb1.size() != 0; i++) step();
        chk(tag, 128'(sb1.size()), 128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [127:0] beat;
        logic [31:0]  w;

        // Reset state, with words waiting in the FIFO.
        repeat (2) step();
        chk("rst_valid", 128'(out_valid4), 128'(0));
        chk("rst_last", 128'(out_last4), 128'(0));
        chk("rst_count", 128'(out_count4), 128'(0));
        chk("rst_data", out_data4, 128'(0));
        chk("rst_valid_r1", 128'(out_valid1), 128'(0));
        push_word4(32'h11);
        push_word4(32'h22);
        push_word4(32'h33);
        push_word4(32'h44);
        chk("rst_fifo_valid", 128'(f4.fillStatus.valid), 128'(1));
        chk("rst_read", 128'(f4.read), 128'(0));
        chk("rst_level", 128'(f4.fillStatus.level), 128'(4));

        // Single full beat and its latency.
        exp4(128'h00000044_00000033_00000022_00000011, 3'd4, 1'b0);
        out_ready = 1'b1;
        rst_n     = 1'b1;
        #1;
        chk("read_after_rst", 128'(f4.read), 128'(1));
        chk("tie_write", 128'(f4.write), 128'(0));
        chk("tie_datain", 128'(f4.datain), 128'(0));
        step();
        step();
        step();
        chk("lat_3rd", 128'(out_valid4), 128'(0));
        step();
        chk("lat_4th", 128'(out_valid4), 128'(1));
        step();
        chk("post_xfer_valid", 128'(out_valid4), 128'(0));
        chk("post_xfer_acc", out_data4, 128'(0));

        // Eight streamed words: two back-to-back beats.
        rd_cyc4.delete();
        xfer_cyc4.delete();
        for (int b = 0; b < 2; b++) begin
            beat = '0;
            for (int i = 0; i < 4; i++) beat[i*32 +: 32] = 32'hA000_0000 + 32'(b * 4 + i);
            exp4(beat, 3'd4, 1'b0);
        end
        for (int i = 0; i < 8; i++) push_word4(32'hA000_0000 + 32'(i));
        drain4("stream_drain");
        chk("stream_reads", 128'(rd_cyc4.size()), 128'(8));
        if (rd_cyc4.size() == 8) chk("stream_no_gap", 128'(rd_cyc4[7] - rd_cyc4[0]), 128'(7));
        chk("stream_beats", 128'(xfer_cyc4.size()), 128'(2));
        if (xfer_cyc4.size() == 2) chk("stream_spacing", 128'(xfer_cyc4[1] - xfer_cyc4[0]), 128'(4));

        // Three words then flush; then flush with nothing pending.
        beat = '0;
        for (int i = 0; i < 3; i++) beat[i*32 +: 32] = 32'hB000_0000 + 32'(i);
        exp4(beat, 3'd3, 1'b1);
        for (int i = 0; i < 3; i++) push_word4(32'hB000_0000 + 32'(i));
        step();
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_valid", 128'(out_valid4), 128'(1));
        chk("flush_last", 128'(out_last4), 128'(1));
        chk("flush_count", 128'(out_count4), 128'(3));
        step();
        chk("flush_done", 128'(out_valid4), 128'(0));
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_empty", 128'(out_valid4), 128'(0));
        step();
        chk("flush_empty_2", 128'(out_valid4), 128'(0));

        // Backpressure in HOLD with the FIFO still holding words.
        out_ready = 1'b0;
        beat = '0;
        for (int i = 0; i < 4; i++) beat[i*32 +: 32] = 32'hC000_0000 + 32'(i);
        exp4(beat, 3'd4, 1'b0);
        for (int i = 0; i < 6; i++) push_word4(32'hC000_0000 + 32'(i));
        for (int i = 0; i < 10; i++) begin
            chk("stall_valid", 128'(out_valid4), 128'(1));
            chk("stall_read", 128'(f4.read), 128'(0));
            chk("stall_data", out_data4, beat);
            chk("stall_level", 128'(f4.fillStatus.level), 128'(2));
            step();
        end

        // Release, take two words (cnt=2), then reset mid-beat.
        out_ready = 1'b1;
        push_word4(32'hC000_0006);
        step();
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 128'(out_valid4), 128'(0));
        chk("midrst_read", 128'(f4.read), 128'(0));
        chk("midrst_fifo", 128'(f4.fillStatus.valid), 128'(1));
        chk("midrst_data", out_data4, 128'(0));
        chk("midrst_count", 128'(out_count4), 128'(0));
        step();
        step();
        beat = '0;
        for (int i = 0; i < 4; i++) beat[i*32 +: 32] = 32'hC000_0006 + 32'(i);
        exp4(beat, 3'd4, 1'b0);
        rst_n = 1'b1;
        for (int i = 7; i < 10; i++) push_word4(32'hC000_0000 + 32'(i));
        drain4("midrst_drain");

        // RATIO=1: continuous stream keeps out_valid high, one beat per word.
        for (int i = 0; i < 8; i++) begin
            w = 32'hD000_0000 + 32'(i);
            exp1(w);
            push_word1(w);
            if (i >= 1) chk("r1_valid", 128'(out_valid1), 128'(1));
        end
        step();
        chk("r1_valid_end", 128'(out_valid1), 128'(1));
        drain1("r1_drain");
        chk("r1_idle", 128'(out_valid1), 128'(0));
        chk("final_sb4", 128'(sb4.size()), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
